// File: rtl/wave_sweep_if.sv
// Site-request and writeback handshake between the sweep controller and the Psi-update datapath.
interface wave_sweep_if #(
    parameter int unsigned COORD_BITS = 6
) ();
    logic                  site_valid;
    logic                  site_ready;
    logic [COORD_BITS-1:0] site_x;
    logic [COORD_BITS-1:0] site_y;
    logic [COORD_BITS-1:0] nbr_w_x;
    logic [COORD_BITS-1:0] nbr_e_x;
    logic [COORD_BITS-1:0] nbr_n_y;
    logic [COORD_BITS-1:0] nbr_s_y;
    logic                  site_last;
    logic                  wb_valid;

    modport master (
        output site_valid, site_x, site_y, nbr_w_x, nbr_e_x, nbr_n_y, nbr_s_y, site_last,
        input  site_ready, wb_valid
    );

    modport slave (
        input  site_valid, site_x, site_y, nbr_w_x, nbr_e_x, nbr_n_y, nbr_s_y, site_last,
        output site_ready, wb_valid
    );
endinterface

// File: rtl/wave_sweep_ctrl.sv
// ARA-WAVE sweep controller: rasters the mesh into the Psi-update pipeline once per
// timestep, drains in-flight sites, then flips the ping-pong read bank.
module wave_sweep_ctrl #(
    parameter int unsigned MESH_X       = 32,
    parameter int unsigned MESH_Y       = 32,
    parameter int unsigned COORD_BITS   = 6,
    parameter int unsigned STEP_BITS    = 16,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [STEP_BITS-1:0] num_steps,
    input  logic [15:0]          dt_in,
    output logic [15:0]          dt_out,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [STEP_BITS-1:0] step_count,
    output logic                 rd_buf_sel,
    output logic                 frame_done,
    output logic                 wb_err,
    wave_sweep_if.master         site
);
    localparam int unsigned           INF_BITS = $clog2(MAX_INFLIGHT + 1);
    localparam logic [INF_BITS-1:0]   INF_MAX  = INF_BITS'(MAX_INFLIGHT);
    localparam logic [COORD_BITS-1:0] X_LAST   = COORD_BITS'(MESH_X - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST   = COORD_BITS'(MESH_Y - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWEEP  = 3'd1,
        S_DRAIN  = 3'd2,
        S_SWAP   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [COORD_BITS-1:0] x_q, y_q, nbr_w_q, nbr_e_q, nbr_n_q, nbr_s_q;
    logic                  last_q;
    logic [INF_BITS-1:0]   inflight_q, inflight_d;
    logic [STEP_BITS-1:0]  steps_q, step_inc;
    logic                  abort_flag_q;

    logic                  site_valid_c, fire, run_load, pos_load;
    logic                  abort_set, finish_abort, swap_go, wb_err_set;
    logic [COORD_BITS-1:0] pos_x_d, pos_y_d;

    function automatic logic [COORD_BITS-1:0] inc_wrap(input logic [COORD_BITS-1:0] v,
                                                       input logic [COORD_BITS-1:0] lim);
        return (v == lim) ? '0 : v + COORD_BITS'(1);
    endfunction

    function automatic logic [COORD_BITS-1:0] dec_wrap(input logic [COORD_BITS-1:0] v,
                                                       input logic [COORD_BITS-1:0] lim);
        return (v == '0) ? lim : v - COORD_BITS'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the strobes that steer the run registers below.
    always_comb begin
        state_d      = state_q;
        site_valid_c = 1'b0;
        fire         = 1'b0;
        run_load     = 1'b0;
        pos_load     = 1'b0;
        pos_x_d      = x_q;
        pos_y_d      = y_q;
        abort_set    = 1'b0;
        finish_abort = 1'b0;
        swap_go      = 1'b0;
        step_inc     = step_count + STEP_BITS'(1);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    run_load = 1'b1;
                    pos_load = 1'b1;
                    pos_x_d  = '0;
                    pos_y_d  = '0;
                    state_d  = (num_steps != '0) ? S_SWEEP : S_FINISH;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    abort_set = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    site_valid_c = (inflight_q < INF_MAX);
                    fire         = site_valid_c && site.site_ready;
                    if (fire) begin
                        pos_load = 1'b1;
                        pos_x_d  = inc_wrap(x_q, X_LAST);
                        pos_y_d  = (x_q == X_LAST) ? inc_wrap(y_q, Y_LAST) : y_q;
                        if (last_q) state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) abort_set = 1'b1;
                if ((inflight_q == '0) && !site.wb_valid) begin
                    if (abort_flag_q || abort) begin
                        finish_abort = 1'b1;
                        state_d      = S_FINISH;
                    end else begin
                        state_d = S_SWAP;
                    end
                end
            end
            S_SWAP: begin
                swap_go  = 1'b1;
                pos_load = 1'b1;
                pos_x_d  = '0;
                pos_y_d  = '0;
                state_d  = (step_inc == steps_q) ? S_FINISH : S_SWEEP;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Simultaneous issue and writeback cancel; a writeback with nothing in flight is an error.
    always_comb begin
        inflight_d = inflight_q;
        wb_err_set = site.wb_valid && (inflight_q == '0);
        if (fire && !site.wb_valid)
            inflight_d = inflight_q + INF_BITS'(1);
        else if (!fire && site.wb_valid && (inflight_q != '0))
            inflight_d = inflight_q - INF_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_done   <= 1'b0;
            aborted      <= 1'b0;
            abort_flag_q <= 1'b0;
            wb_err       <= 1'b0;
            rd_buf_sel   <= 1'b0;
            step_count   <= '0;
            steps_q      <= '0;
            dt_out       <= '0;
            inflight_q   <= '0;
            x_q          <= '0;
            y_q          <= '0;
            nbr_w_q      <= '0;
            nbr_e_q      <= '0;
            nbr_n_q      <= '0;
            nbr_s_q      <= '0;
            last_q       <= 1'b0;
        end else begin
            busy       <= (state_d != S_IDLE);
            done       <= (state_q == S_FINISH);
            frame_done <= swap_go;
            inflight_q <= inflight_d;
            if (run_load) begin
                steps_q      <= num_steps;
                dt_out       <= dt_in;
                step_count   <= '0;
                aborted      <= 1'b0;
                abort_flag_q <= 1'b0;
            end else begin
                if (abort_set)    abort_flag_q <= 1'b1;
                if (finish_abort) aborted      <= 1'b1;
                if (swap_go) begin
                    rd_buf_sel <= ~rd_buf_sel;
                    step_count <= step_inc;
                end
            end
            if (wb_err_set)    wb_err <= 1'b1;
            else if (run_load) wb_err <= 1'b0;
            // Neighbours are derived from the next position so they change with site_x/site_y.
            if (pos_load) begin
                x_q     <= pos_x_d;
                y_q     <= pos_y_d;
                nbr_w_q <= dec_wrap(pos_x_d, X_LAST);
                nbr_e_q <= inc_wrap(pos_x_d, X_LAST);
                nbr_n_q <= dec_wrap(pos_y_d, Y_LAST);
                nbr_s_q <= inc_wrap(pos_y_d, Y_LAST);
                last_q  <= (pos_x_d == X_LAST) && (pos_y_d == Y_LAST);
            end
        end
    end

    assign site.site_valid = site_valid_c;
    assign site.site_x     = x_q;
    assign site.site_y     = y_q;
    assign site.nbr_w_x    = nbr_w_q;
    assign site.nbr_e_x    = nbr_e_q;
    assign site.nbr_n_y    = nbr_n_q;
    assign site.nbr_s_y    = nbr_s_q;
    assign site.site_last  = last_q;
endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Scoreboard bench for wave_sweep_ctrl: raster/neighbour model, writeback pipeline model,
// and per-run frame/done expectations checked by an independent monitor.
module tb_wave_sweep_ctrl;
    localparam int unsigned MX    = 32;
    localparam int unsigned MY    = 32;
    localparam int unsigned CB    = 6;
    localparam int unsigned SB    = 16;
    localparam int unsigned MAXI  = 8;
    localparam int          NSITE = MX * MY;
    localparam int unsigned PW    = 6 * CB + 1;
    localparam int unsigned DW    = SB + 18;

    logic          clk, rst_n, start, abort;
    logic [SB-1:0] num_steps, step_count;
    logic [15:0]   dt_in, dt_out;
    logic          busy, done, aborted, rd_buf_sel, frame_done, wb_err;

    wave_sweep_if #(.COORD_BITS(CB)) bus ();

    wave_sweep_ctrl #(
        .MESH_X(MX), .MESH_Y(MY), .COORD_BITS(CB), .STEP_BITS(SB), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_steps(num_steps), .dt_in(dt_in), .dt_out(dt_out),
        .busy(busy), .done(done), .aborted(aborted), .step_count(step_count),
        .rd_buf_sel(rd_buf_sel), .frame_done(frame_done), .wb_err(wb_err),
        .site(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fire_cnt = 0;
    int done_cnt = 0;
    int m_inflight = 0;
    int lat_cfg = 4;
    int ready_pct = 100;
    bit spur_wb = 0;
    bit m_bank = 0;
    bit prev_stall = 0;
    logic [PW-1:0] prev_pos;
    logic [PW-1:0] exp_sites[$];
    logic [SB:0]   exp_frame[$];
    logic [DW-1:0] exp_done[$];
    int            wbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected request word for raster index k, neighbours by modular arithmetic.
    function automatic logic [PW-1:0] site_word(input int k);
        int x, y;
        x = k % MX;
        y = k / MX;
        return {CB'(x), CB'(y), CB'((x + MX - 1) % MX), CB'((x + 1) % MX),
                CB'((y + MY - 1) % MY), CB'((y + 1) % MY), 1'(k == NSITE - 1)};
    endfunction

    task automatic plan_run(input int steps, input int stop_at, input logic [15:0] dt);
        int total, completed;
        total     = (stop_at < 0) ? steps * NSITE : stop_at;
        completed = total / NSITE;
        for (int i = 0; i < total; i++) exp_sites.push_back(site_word(i % NSITE));
        for (int s = 1; s <= completed; s++) begin
            m_bank = ~m_bank;
            exp_frame.push_back({SB'(s), m_bank});
        end
        exp_done.push_back({1'(stop_at >= 0), SB'(completed), m_bank, dt});
    endtask

    task automatic do_start(input int steps, input int stop_at);
        logic [15:0] dt;
        @(posedge clk); #1;
        dt        = 16'($urandom);
        num_steps = SB'(steps);
        dt_in     = dt;
        fire_cnt  = 0;
        start     = 1'b1;
        plan_run(steps, stop_at, dt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts negedges from the one after start was taken; optional ignored start pulse mid-run.
    task automatic wait_done(input int budget, input int pulse_k, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (k == pulse_k) begin
                start     = 1'b1;
                num_steps = SB'(7);
                dt_in     = 16'h1234;
            end else if (k == pulse_k + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic apply_reset(input string tag);
        logic [127:0] v;
        rst_n = 1'b0;
        #1;
        v = 128'({busy, done, aborted, step_count, rd_buf_sel, frame_done, wb_err, dt_out,
                  bus.site_valid, bus.site_x, bus.site_y, bus.nbr_w_x, bus.nbr_e_x,
                  bus.nbr_n_y, bus.nbr_s_y, bus.site_last});
        chk(tag, longint'(v[63:0]) | longint'(v[127:64]), 0);
        exp_sites.delete();
        exp_frame.delete();
        exp_done.delete();
        wbq.delete();
        m_inflight   = 0;
        m_bank       = 0;
        prev_stall   = 0;
        start        = 1'b0;
        abort        = 1'b0;
        bus.wb_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Datapath model: fixed-latency in-order writebacks, randomised ready.
    always @(posedge clk) begin
        #1;
        cyc++;
        bus.wb_valid = 1'b0;
        if (rst_n) begin
            if (spur_wb) begin
                bus.wb_valid = 1'b1;
                spur_wb      = 0;
            end else if (wbq.size() > 0 && wbq[0] <= cyc) begin
                void'(wbq.pop_front());
                bus.wb_valid = 1'b1;
            end
        end
        bus.site_ready = (ready_pct >= 100) ? 1'b1 : 1'($urandom_range(99) < ready_pct);
    end

    // Monitor: pops expectations whenever the DUT presents a fire, frame or done.
    always @(negedge clk) begin
        logic [PW-1:0] cur, expw;
        logic [DW-1:0] dgot, dexp;
        logic [SB:0]   fgot, fexp;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            cur = {bus.site_x, bus.site_y, bus.nbr_w_x, bus.nbr_e_x,
                   bus.nbr_n_y, bus.nbr_s_y, bus.site_last};
            if (prev_stall && !abort) begin
                checks++;
                if (!bus.site_valid || cur != prev_pos) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b pos=%h, required valid=1 pos=%h",
                             bus.site_valid, cur, prev_pos);
                end
            end
            prev_stall = bus.site_valid && !bus.site_ready;
            prev_pos   = cur;
            if (bus.site_valid && bus.site_ready) begin
                checks++;
                if (m_inflight >= int'(MAXI)) begin
                    errors++;
                    $display("FAIL inflight_cap: issue with %0d in flight, required below %0d",
                             m_inflight, MAXI);
                end
                checks++;
                if (exp_sites.size() == 0) begin
                    errors++;
                    $display("FAIL site_unexpected: fire at %h, required no fire", cur);
                end else begin
                    expw = exp_sites.pop_front();
                    if (cur != expw) begin
                        errors++;
                        $display("FAIL site_order: got %h, required %h", cur, expw);
                    end
                end
                fire_cnt++;
                m_inflight++;
                wbq.push_back(cyc + lat_cfg);
            end
            if (bus.wb_valid && m_inflight > 0) m_inflight--;
            if (frame_done) begin
                fgot = {step_count, rd_buf_sel};
                fexp = (exp_frame.size() > 0) ? exp_frame.pop_front() : '1;
                chk("frame_state", fgot, fexp);
            end
            if (done) begin
                done_cnt++;
                dgot = {aborted, step_count, rd_buf_sel, dt_out};
                dexp = (exp_done.size() > 0) ? exp_done.pop_front() : '1;
                chk("done_state", dgot, dexp);
            end
        end
    end

    initial begin
        int lat, d0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        num_steps = '0; dt_in = '0;
        bus.site_ready = 1'b0; bus.wb_valid = 1'b0;
        #3;
        apply_reset("reset_outputs");

        // Full-rate single step, with a start pulse while busy that must be ignored.
        do_start(1, -1);
        wait_done(3000, 300, lat);
        chk("single_latency", lat, NSITE + lat_cfg + 3);
        chk("single_fires", fire_cnt, NSITE);
        chk("single_bank", rd_buf_sel, 1);

        // Writeback with nothing in flight.
        @(negedge clk); spur_wb = 1;
        repeat (3) @(negedge clk);
        chk("wb_err_set", wb_err, 1);
        repeat (5) @(negedge clk);
        chk("wb_err_hold", wb_err, 1);

        do_start(0, -1);
        chk("wb_err_clear", wb_err, 0);
        wait_done(20, -1, lat);
        chk("zero_latency", lat, 1);
        chk("zero_fires", fire_cnt, 0);

        // Reset in the middle of a sweep.
        do_start(2, -1);
        for (int k = 0; k < 500 && fire_cnt < 100; k++) @(posedge clk);
        chk("pre_reset_fires", fire_cnt >= 100, 1);
        @(negedge clk); #2;
        apply_reset("midsweep_reset");
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("no_done_after_reset", done_cnt, d0);

        // Backpressure with a pipeline longer than the in-flight window.
        lat_cfg = 12; ready_pct = 50;
        do_start(3, -1);
        wait_done(40000, -1, lat);
        chk("bp_fires", fire_cnt, 3 * NSITE);
        chk("bp_bank", rd_buf_sel, 1);
        chk("bp_steps", step_count, 3);
        lat_cfg = 4; ready_pct = 100;
        repeat (2) @(negedge clk);
        apply_reset("reset_outputs2");

        // Abort at raster index 500 of the second step.
        do_start(4, NSITE + 500);
        for (int k = 0; k < 5000 && fire_cnt < NSITE + 500; k++) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_stop", bus.site_valid, 0);
        chk("abort_fires", fire_cnt, NSITE + 500);
        wait_done(200, -1, lat);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("aborted_hold", aborted, 1);
        chk("abort_idle", busy, 0);

        chk("leftover_sites", exp_sites.size(), 0);
        chk("leftover_frames", exp_frame.size(), 0);
        chk("leftover_done", exp_done.size(), 0);
        chk("inflight_drained", m_inflight, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
